pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
- Program-counter and fetch-control stage of the instruction fetch unit.
- Holds the PC register and drives PCResult to the PC adder. Takes PCAddResult back as the sequential next PC.
- Issues a request/acknowledge fetch to instruction memory and presents the fetched word to decode through a valid/ready handshake.
- Supports branch/jump redirect, including a redirect that arrives while a memory fetch is still outstanding.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset (bits [1:0] must be 00).
- TIMEOUT_CYCLES, 16, number of consecutive REQ cycles without IMemAck before a fetch error is raised (range 2..255).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- PCAddResult  input  32  PC+4 from the PC adder.
- PCResult  output  32  current PC register value, sent to the PC adder.
- Redirect  input  1  branch/jump taken this cycle.
- BranchTarget  input  32  redirect target; sampled only when Redirect=1.
- IMemReq  output  1  fetch request to instruction memory.
- IMemAddr  output  32  fetch address; stable while IMemReq=1 and no ack.
- IMemAck  input  1  memory returns data this cycle.
- IMemData  input  32  instruction word; valid when IMemAck=1.
- Instruction  output  32  fetched instruction to decode.
- InstrPC  output  32  PC of Instruction.
- InstrValid  output  1  Instruction/InstrPC valid.
- InstrReady  input  1  decode accepts this cycle.
- FetchError  output  1  sticky memory-timeout flag.

Behaviour:
- Reset=0, taking effect asynchronously:
  - PCResult=RESET_PC; IMemReq=0; InstrValid=0; Instruction=0; InstrPC=0; FetchError=0.
  - state=IDLE; kill=0; pending=0; wait counter=0.
- States are IDLE, REQ, HOLD and ERR. IMemReq=1 only in REQ. IMemAddr=PCResult in REQ, otherwise 0. InstrValid=1 only in HOLD.
- IDLE: moves to REQ on the first edge after Reset deasserts. A Redirect in IDLE loads the aligned target into PCResult.
- Target alignment: the target is always {BranchTarget[31:2],2'b00}, so misaligned low bits are cleared.
- REQ:
  - Ack, kill=0, no Redirect: Instruction<=IMemData; InstrPC<=PCResult; PCResult<=PCAddResult; go to HOLD. Fetch latency is one edge from ack to InstrValid.
  - Ack with Redirect in the same cycle: discard the data; PCResult<=aligned target; stay in REQ.
  - Ack with kill=1: discard the data; PCResult<=pending; kill<=0; stay in REQ.
  - Redirect without ack: pending<=aligned target; kill<=1. IMemAddr is unchanged until the ack, because the address is held stable. A later Redirect overwrites pending.
  - The wait counter increments on each REQ cycle without ack and clears on ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack: go to ERR.
- HOLD:
  - Instruction and InstrPC are held stable until the handshake.
  - InstrValid & InstrReady: go to REQ next cycle.
  - Redirect, regardless of InstrReady: InstrValid drops next cycle (flush); PCResult<=aligned target; go to REQ.
- ERR: FetchError=1; IMemReq=0. Redirect and IMemAck are ignored. Only Reset leaves ERR.
- Wrap-around: PCAddResult is taken as given, so PCResult=FFFFFFFC followed by a fetch gives PCResult=00000000.
- Reset mid-fetch: everything returns to reset values immediately. A late IMemAck arriving in IDLE is ignored.
- Throughput: 1 instruction per 2 cycles minimum, with zero-wait memory and InstrReady held at 1.

Test Plan:
- Reset: RESET_PC=0. Release Reset; memory acks every REQ cycle with data=PC^32'hA5A5A5A5; InstrReady=1.
  -> InstrPC sequence 0,4,8,C.
  -> Instruction for PC 8 = A5A5A5AD.
  -> InstrValid pulses every second cycle.
- Backpressure: InstrReady=0 for 5 cycles while in HOLD.
  -> Instruction/InstrPC are held and IMemReq=0.
  -> Raising InstrReady gives IMemReq=1 on the next cycle with IMemAddr=next PC.
- Redirect in HOLD: Redirect=1 with BranchTarget=32'h00000103 while in HOLD.
  -> InstrValid=0 next cycle.
  -> IMemAddr=32'h00000100.
- Redirect during outstanding fetch: IMemAck delayed 3 cycles; Redirect=1 with BranchTarget=0x200 in the first wait cycle.
  -> IMemAddr stays at the old PC until the ack.
  -> The returned data never appears on InstrValid.
  -> The next request has IMemAddr=0x200.
- Timeout and reset: no IMemAck for 16 REQ cycles.
  -> FetchError=1 and IMemReq=0.
  -> Redirect is ignored.
  -> Asserting Reset low clears FetchError asynchronously and sets PCResult=RESET_PC.
- Wrap: RESET_PC=32'hFFFFFFFC with one fetch.
  -> InstrPC=FFFFFFFC.
  -> Next IMemAddr=00000000.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// Program-counter and fetch-control stage: owns the PC, issues req/ack fetches
// to instruction memory and hands fetched words to decode over valid/ready.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCAddResult,
  output logic [31:0] PCResult,
  input  logic        Redirect,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic        FetchError
);

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_pend;
  logic [31:0] w_pend_nxt;
  logic        r_kill;
  logic        w_kill_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        w_capture;
  logic [31:0] w_target;

  function automatic logic [31:0] f_align(input logic [31:0] target);
    return target & 32'hFFFF_FFFC;
  endfunction

  assign w_target = f_align(BranchTarget);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    w_kill_nxt  = r_kill;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (Redirect) w_pc_nxt = w_target;
      end
      S_REQ: begin
        if (IMemAck) begin
          w_cnt_nxt  = '0;
          w_kill_nxt = 1'b0;
          // Newest redirect wins; a killed fetch resumes at the parked target.
          if (Redirect)    w_pc_nxt = w_target;
          else if (r_kill) w_pc_nxt = r_pend;
          else begin
            w_capture   = 1'b1;
            w_pc_nxt    = PCAddResult;
            w_state_nxt = S_HOLD;
          end
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
          // The address must stay stable until ack, so park the target.
          if (Redirect) begin
            w_pend_nxt = w_target;
            w_kill_nxt = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (Redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_REQ;
        end else if (InstrReady) begin
          w_state_nxt = S_REQ;
        end
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc       <= RESET_PC;
      r_pend     <= '0;
      r_kill     <= 1'b0;
      r_cnt      <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_pend <= w_pend_nxt;
      r_kill <= w_kill_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_capture) begin
        r_instr    <= IMemData;
        r_instr_pc <= r_pc;
      end
    end
  end

  assign PCResult    = r_pc;
  assign IMemReq     = (r_state == S_REQ);
  assign IMemAddr    = (r_state == S_REQ) ? r_pc : 32'h0;
  assign InstrValid  = (r_state == S_HOLD);
  assign Instruction = r_instr;
  assign InstrPC     = r_instr_pc;
  assign FetchError  = (r_state == S_ERR);

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: sequential fetch, backpressure, redirects,
// timeout/async reset, and PC wrap on a second instance with RESET_PC=FFFFFFFC.
module tb_pc_fetch_stage;

  logic        Clk;
  logic        Reset;
  logic [31:0] PCAddResult;
  logic [31:0] PCResult;
  logic        Redirect;
  logic [31:0] BranchTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        ack;
  logic [31:0] IMemData;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        FetchError;

  logic        rst2_n;
  logic [31:0] pcadd2;
  logic [31:0] pc2;
  logic        redir2;
  logic [31:0] tgt2;
  logic        req2;
  logic [31:0] addr2;
  logic        ack2;
  logic [31:0] data2;
  logic [31:0] instr2;
  logic [31:0] ipc2;
  logic        vld2;
  logic        ready2;
  logic        err2;

  int n_chk;
  int n_pass;

  assign PCAddResult = PCResult + 32'd4;
  assign IMemData    = IMemAddr ^ 32'hA5A5_A5A5;
  assign pcadd2      = pc2 + 32'd4;
  assign data2       = addr2 ^ 32'hA5A5_A5A5;

  pc_fetch_stage #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) u_dut (
    .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult), .PCResult(PCResult),
    .Redirect(Redirect), .BranchTarget(BranchTarget), .IMemReq(IMemReq),
    .IMemAddr(IMemAddr), .IMemAck(ack), .IMemData(IMemData),
    .Instruction(Instruction), .InstrPC(InstrPC), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .FetchError(FetchError)
  );

  pc_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) u_dut_wrap (
    .Clk(Clk), .Reset(rst2_n), .PCAddResult(pcadd2), .PCResult(pc2),
    .Redirect(redir2), .BranchTarget(tgt2), .IMemReq(req2),
    .IMemAddr(addr2), .IMemAck(ack2), .IMemData(data2),
    .Instruction(instr2), .InstrPC(ipc2), .InstrValid(vld2),
    .InstrReady(ready2), .FetchError(err2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    Reset = 1'b1; rst2_n = 1'b1;
    Redirect = 1'b0; BranchTarget = '0; ack = 1'b1; InstrReady = 1'b1;
    redir2 = 1'b0; tgt2 = '0; ack2 = 1'b1; ready2 = 1'b1;
    #1;
    Reset = 1'b0; rst2_n = 1'b0;
    step(); step();

    chk("rst_pc",    PCResult, 32'h0);
    chk("rst_req",   32'(IMemReq), 32'h0);
    chk("rst_vld",   32'(InstrValid), 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_ipc",   InstrPC, 32'h0);
    chk("rst_err",   32'(FetchError), 32'h0);
    chk("rst2_pc",   pc2, 32'hFFFF_FFFC);

    // Sequential fetch with zero-wait memory and decode always ready
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("seq_vld", 32'(InstrValid), 32'(i % 2));
      chk("seq_req", 32'(IMemReq), 32'((i + 1) % 2));
      if (i % 2 == 0) chk("seq_addr", IMemAddr, 32'((i / 2) * 4));
      else            chk("seq_ipc", InstrPC, 32'((i / 2) * 4));
      if (i == 5)     chk("seq_instr8", Instruction, 32'hA5A5_A5AD);
    end

    // Backpressure in HOLD (InstrPC=C)
    InstrReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_vld",   32'(InstrValid), 32'h1);
      chk("bp_ipc",   InstrPC, 32'h0000_000C);
      chk("bp_instr", Instruction, 32'hA5A5_A5A9);
      chk("bp_req",   32'(IMemReq), 32'h0);
    end
    InstrReady = 1'b1;
    step();
    chk("bp_rel_req",  32'(IMemReq), 32'h1);
    chk("bp_rel_addr", IMemAddr, 32'h0000_0010);

    // Redirect in HOLD with misaligned target, decode not ready
    step();
    chk("rh_hold_ipc", InstrPC, 32'h0000_0010);
    Redirect = 1'b1; BranchTarget = 32'h0000_0103; InstrReady = 1'b0;
    step();
    Redirect = 1'b0; InstrReady = 1'b1;
    chk("rh_vld",  32'(InstrValid), 32'h0);
    chk("rh_addr", IMemAddr, 32'h0000_0100);
    step();
    chk("rh_ipc",   InstrPC, 32'h0000_0100);
    chk("rh_instr", Instruction, 32'hA5A5_A4A5);

    // Redirect while a fetch is outstanding
    ack = 1'b0;
    step();
    chk("ro_addr0", IMemAddr, 32'h0000_0104);
    Redirect = 1'b1; BranchTarget = 32'h0000_0200;
    step();
    Redirect = 1'b0;
    chk("ro_addr1", IMemAddr, 32'h0000_0104);
    step();
    chk("ro_addr2", IMemAddr, 32'h0000_0104);
    step();
    chk("ro_addr3", IMemAddr, 32'h0000_0104);
    chk("ro_vld3",  32'(InstrValid), 32'h0);
    ack = 1'b1;
    step();
    chk("ro_vld4",  32'(InstrValid), 32'h0);
    chk("ro_req4",  32'(IMemReq), 32'h1);
    chk("ro_addr4", IMemAddr, 32'h0000_0200);
    step();
    chk("ro_vld5",   32'(InstrValid), 32'h1);
    chk("ro_ipc5",   InstrPC, 32'h0000_0200);
    chk("ro_instr5", Instruction, 32'hA5A5_A7A5);

    // Timeout: 16 REQ cycles without ack
    ack = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("to_req", 32'(IMemReq), 32'h1);
      chk("to_err", 32'(FetchError), 32'h0);
      step();
    end
    chk("to_err_set", 32'(FetchError), 32'h1);
    chk("to_req_off", 32'(IMemReq), 32'h0);
    chk("to_addr",    IMemAddr, 32'h0);
    Redirect = 1'b1; BranchTarget = 32'h0000_0300; ack = 1'b1;
    step(); step();
    Redirect = 1'b0;
    chk("err_sticky", 32'(FetchError), 32'h1);
    chk("err_pc",     PCResult, 32'h0000_0204);
    chk("err_req",    32'(IMemReq), 32'h0);

    // Asynchronous reset mid-cycle, with ack still high
    #3;
    Reset = 1'b0;
    #1;
    chk("arst_err",   32'(FetchError), 32'h0);
    chk("arst_pc",    PCResult, 32'h0);
    chk("arst_req",   32'(IMemReq), 32'h0);
    chk("arst_vld",   32'(InstrValid), 32'h0);
    chk("arst_instr", Instruction, 32'h0);
    chk("arst_ipc",   InstrPC, 32'h0);
    step();
    Reset = 1'b1; rst2_n = 1'b1;
    step();
    chk("idle_ack_vld", 32'(InstrValid), 32'h0);
    chk("idle_ack_req", 32'(IMemReq), 32'h1);
    chk("idle_ack_addr", IMemAddr, 32'h0);

    // PC wrap on the second instance
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    step();
    chk("wrap_vld", 32'(vld2), 32'h1);
    chk("wrap_ipc", ipc2, 32'hFFFF_FFFC);
    chk("wrap_pc",  pc2, 32'h0);
    step();
    chk("wrap_addr1", addr2, 32'h0);
    chk("wrap_req1",  32'(req2), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
